// File: rtl/tone_pkg.sv
// Shared definitions for the tone decoder and the beep generator:
// note period constants (clk cycles at 50 MHz), the "no note" code,
// the decoder state type and the period classifier.
package tone_pkg;

    localparam logic [31:0] L1 = 32'd191130;
    localparam logic [31:0] L2 = 32'd170241;
    localparam logic [31:0] L3 = 32'd151698;
    localparam logic [31:0] L4 = 32'd143183;
    localparam logic [31:0] L5 = 32'd127550;
    localparam logic [31:0] L6 = 32'd113635;
    localparam logic [31:0] L7 = 32'd101234;

    localparam logic [2:0] NOTE_NONE = 3'd0;

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        LOCKED
    } state_t;

    function automatic logic [31:0] note_period(input logic [2:0] k);
        case (k)
            3'd1:    return L1;
            3'd2:    return L2;
            3'd3:    return L3;
            3'd4:    return L4;
            3'd5:    return L5;
            3'd6:    return L6;
            3'd7:    return L7;
            default: return 32'd0;
        endcase
    endfunction

    // Returns the lowest note whose window (Lk >> tol_shift around Lk)
    // contains the period, or NOTE_NONE. note_shift scales every note
    // period down by a power of two for slower clocks or short runs.
    function automatic logic [2:0] classify(input logic [31:0] period,
                                            input int note_shift,
                                            input int tol_shift);
        logic [2:0]         k;
        logic [31:0]        ref_p;
        logic [31:0]        tol;
        logic signed [32:0] diff;
        logic signed [32:0] mag;
        k = NOTE_NONE;
        if (period >= 32'd4) begin
            for (int i = 1; i <= 7; i++) begin
                ref_p = note_period(3'(i)) >> note_shift;
                tol   = ref_p >> tol_shift;
                diff  = $signed({1'b0, period}) - $signed({1'b0, ref_p});
                mag   = diff[32] ? -diff : diff;
                if (k == NOTE_NONE && mag <= $signed({1'b0, tol})) begin
                    k = 3'(i);
                end
            end
        end
        return k;
    endfunction

endpackage

// File: rtl/tone_edge_sync.sv
// Two-flop synchronizer for an asynchronous pin-level tone, followed by
// registered rising and falling edge pulses (one clk wide, 3 clk after
// the pin transition).
module tone_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [2:0] sync;

    // Shift the pin through the synchronizer and compare the last two taps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 3'b000;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            sync <= {sync[1:0], din};
            rise <= sync[1] & ~sync[2];
            fall <= ~sync[1] & sync[2];
        end
    end

endmodule

// File: rtl/tone_decoder.sv
// Measures the period of an incoming square-wave tone and decodes it to
// note 1..7 after CONFIRM consecutive matching periods; drops the note
// after CONFIRM misses or after TIMEOUT_CYC clk without a rising edge.
// Optional macro TONE_DUTY_CHECK_EN: periods whose high time falls
// outside [period/4, 3*period/4] are treated as unmatched.
// NOTE_SHIFT divides all note periods by 2**NOTE_SHIFT (0 for 50 MHz).
module tone_decoder
    import tone_pkg::*;
#(
    parameter int CONFIRM     = 3,
    parameter int TOL_SHIFT   = 6,
    parameter int TIMEOUT_CYC = 400000,
    parameter int NOTE_SHIFT  = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tone_in,
    output logic [2:0]  note_idx,
    output logic        note_valid,
    output logic        note_strobe,
    output logic [31:0] period_out
);

    localparam logic [3:0]  CONFIRM_N = 4'(CONFIRM);
    localparam logic [31:0] TIMEOUT_N = 32'(TIMEOUT_CYC);

    state_t      state;
    logic        edge_rise;
    logic [31:0] period_cnt;
    logic        cap_valid;
    logic [2:0]  cls_k;
    logic [2:0]  cand_k;
    logic [3:0]  cand_cnt;
    logic [3:0]  cand_next;
    logic [3:0]  miss_cnt;
    logic [3:0]  miss_next;

`ifdef TONE_DUTY_CHECK_EN
    logic        edge_fall;
    logic [31:0] high_cnt;
    logic [31:0] high_time;
    logic [31:0] high_cap;
`else
    logic        unused_fall;
`endif

    tone_edge_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (tone_in),
        .rise  (edge_rise),
`ifdef TONE_DUTY_CHECK_EN
        .fall  (edge_fall)
`else
        .fall  (unused_fall)
`endif
    );

    // Free-running period counter, restarted by each rising edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt <= 32'd0;
        end else if (edge_rise) begin
            period_cnt <= 32'd1;
        end else if (period_cnt < TIMEOUT_N) begin
            period_cnt <= period_cnt + 32'd1;
        end
    end

    // Capture the period on every edge that has a reference edge before it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_out <= 32'd0;
            cap_valid  <= 1'b0;
        end else begin
            cap_valid <= edge_rise && (state != IDLE);
            if (edge_rise && (state != IDLE)) begin
                period_out <= period_cnt;
            end
        end
    end

`ifdef TONE_DUTY_CHECK_EN
    // Track the high time of the current cycle and hold it with its period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            high_cnt  <= 32'd0;
            high_time <= 32'd0;
            high_cap  <= 32'd0;
        end else begin
            if (edge_rise) begin
                high_cnt <= 32'd1;
            end else if (high_cnt != 32'hFFFF_FFFF) begin
                high_cnt <= high_cnt + 32'd1;
            end
            if (edge_fall) begin
                high_time <= high_cnt;
            end
            if (edge_rise && (state != IDLE)) begin
                high_cap <= high_time;
            end
        end
    end
`endif

    // Classify the captured period and work out the next candidate/miss counts
    always_comb begin
        cls_k = classify(period_out, NOTE_SHIFT, TOL_SHIFT);
`ifdef TONE_DUTY_CHECK_EN
        if (({high_cap, 2'b00} < {2'b00, period_out}) ||
            ({high_cap, 2'b00} > ({2'b00, period_out} + {1'b0, period_out, 1'b0}))) begin
            cls_k = NOTE_NONE;
        end
`endif
        cand_next = 4'd0;
        if (cls_k != NOTE_NONE) begin
            if (cls_k == cand_k) begin
                cand_next = (cand_cnt == 4'hF) ? cand_cnt : cand_cnt + 4'd1;
            end else begin
                cand_next = 4'd1;
            end
        end
        miss_next = (miss_cnt == 4'hF) ? miss_cnt : miss_cnt + 4'd1;
    end

    // Lock, switch, drop and timeout decisions with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            note_idx    <= NOTE_NONE;
            note_valid  <= 1'b0;
            note_strobe <= 1'b0;
            cand_k      <= NOTE_NONE;
            cand_cnt    <= 4'd0;
            miss_cnt    <= 4'd0;
        end else begin
            note_strobe <= 1'b0;
            if (edge_rise && (state == IDLE)) begin
                state <= MEASURE;
            end else if ((state != IDLE) && (period_cnt == TIMEOUT_N)) begin
                state       <= IDLE;
                cand_k      <= NOTE_NONE;
                cand_cnt    <= 4'd0;
                miss_cnt    <= 4'd0;
                note_idx    <= NOTE_NONE;
                note_valid  <= 1'b0;
                note_strobe <= note_valid;
            end else if (cap_valid && (state != IDLE)) begin
                cand_k   <= cls_k;
                cand_cnt <= cand_next;
                case (state)
                    MEASURE: begin
                        if ((cls_k != NOTE_NONE) && (cand_next >= CONFIRM_N)) begin
                            state       <= LOCKED;
                            note_idx    <= cls_k;
                            note_valid  <= 1'b1;
                            note_strobe <= 1'b1;
                            miss_cnt    <= 4'd0;
                        end
                    end
                    LOCKED: begin
                        if ((cls_k != NOTE_NONE) && (cls_k != note_idx) &&
                            (cand_next >= CONFIRM_N)) begin
                            note_idx    <= cls_k;
                            note_strobe <= 1'b1;
                            miss_cnt    <= 4'd0;
                        end else if (cls_k != note_idx) begin
                            if (miss_next >= CONFIRM_N) begin
                                state       <= MEASURE;
                                note_idx    <= NOTE_NONE;
                                note_valid  <= 1'b0;
                                note_strobe <= 1'b1;
                                miss_cnt    <= 4'd0;
                            end else begin
                                miss_cnt <= miss_next;
                            end
                        end else begin
                            miss_cnt <= 4'd0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/tone_decoder.md
Name: tone_decoder

Overview:
- Receive-side counterpart of the PWM beep path. Measures the period of an incoming square-wave tone (e.g. a looped-back buzzer drive or an external pin) and decodes it to note index 1..7 (L1..L7 scale).
- A note is reported only after CONFIRM consecutive matching periods. Loss of tone is detected by timeout.
- Sits beside the beep generator for self-test and for melody capture.

Parameters:
- CONFIRM, 3, consecutive periods needed to lock or to drop a note (range 1..15)
- TOL_SHIFT, 6, match tolerance per note k is Lk >> TOL_SHIFT (about 1.56%)
- TIMEOUT_CYC, 400000, clk cycles with no rising edge before the tone is declared absent

Ports:
- clk, input, 1, system clock, 50 MHz
- rst_n, input, 1, asynchronous active-low reset
- tone_in, input, 1, asynchronous square-wave tone input
- note_idx, output, 3, decoded note 1..7; 0 means no note
- note_valid, output, 1, high while a note is locked
- note_strobe, output, 1, one-cycle pulse whenever note_idx or note_valid changes
- period_out, output, 32, last measured period in clk cycles

Behaviour:
- Reset and interface: rst_n asynchronous, active-low; clock clk. On reset all outputs are 0, state is IDLE, and all counters are 0.
- Input edge detect: tone_in passes a 2-FF synchronizer, then a registered rising-edge detect, producing a one-cycle edge pulse 3 clk after the pin rises.
- Period counter: 32-bit, increments every cycle and saturates at TIMEOUT_CYC.
  - On an edge, the captured period equals the counter value and the counter loads 1.
  - Edges spaced P clk apart therefore capture exactly P.
- States:
  - IDLE: no reference edge yet. On the first edge, go to MEASURE; no period is captured.
  - MEASURE: for each edge, capture the period, update period_out, and classify. CONFIRM consecutive periods matching the same k≠0 lock note k: go to LOCKED, set note_idx=k, note_valid=1, pulse note_strobe.
  - LOCKED: per captured period, in priority order:
    - (a) A candidate j≠note_idx reaching CONFIRM matches switches to j directly, with one strobe and note_valid held high.
    - (b) CONFIRM consecutive periods not matching note_idx set note_idx=0, note_valid=0, pulse strobe, and go to MEASURE.
    - (c) A period matching note_idx clears the miss count.
  - Any state: counter reaching TIMEOUT_CYC goes to IDLE, clears candidate and miss counts, and sets note_idx=0, note_valid=0. Strobe pulses only if note_valid was 1.
- Classification:
  - Match k when the absolute value of (period − Lk) ≤ Lk >> TOL_SHIFT. Use 33-bit signed difference.
  - Tolerance windows are disjoint for TOL_SHIFT ≥ 6, so the lowest matching k wins. No match gives k=0.
  - A k=0 period resets the candidate count.
  - A period matching a new k restarts the candidate count at 1.
- Latency:
  - Classification is registered, one cycle after capture.
  - Outputs update 2 clk after the edge pulse, i.e. 5 clk after the pin edge.
  - period_out updates 1 clk after the edge pulse.
- Limits: periods below 4 clk are captured but never match. Reset mid-operation returns everything to the reset state immediately.

Optional Feature:
- Macro TONE_DUTY_CHECK_EN.
- When defined: also count high-time from rising to falling edge. A period whose high-time is outside [period/4, 3·period/4] is classified k=0 regardless of frequency.
- When undefined: duty cycle is ignored and no high-time counter is built.

Decomposition:
- Package tone_pkg:
  - Note period constants L1=191130, L2=170241, L3=151698, L4=143183, L5=127550, L6=113635, L7=101234 (shared with the beep generator).
  - NOTE_NONE=0.
  - State enum IDLE/MEASURE/LOCKED.
- Sub-module tone_edge_sync: 2-FF synchronizer plus rising/falling edge pulses, reused by any pin-level tone input.

Test Plan:
- Reset: assert rst_n=0 mid-stream. Required: note_idx=0, note_valid=0, note_strobe=0, period_out=0 immediately; after release, decoding restarts from IDLE.
- 50% square wave, period 127550. Required:
  - period_out=127550 after the 2nd edge.
  - note_idx=5, note_valid=1 and a single strobe 2 clk after the 4th edge.
- Locked on 5, then periods of 129400 (within tolerance 1992). Required: stays 5, no strobe.
- Locked on 5, then three periods of 135000. Required: note_idx=0, note_valid=0, one strobe after the 3rd.
- Switch 127550 to 170241. Required: after 3 L2 periods, note_idx=2 with exactly one strobe and note_valid never low.
- Tone held low after lock. Required: 400000 clk after the last edge, note_valid=0 with one strobe. With TONE_DUTY_CHECK_EN defined, a 10%-duty 127550 wave never locks.
